// File: rtl/can_crc_pkg.sv
// Shared definitions for the CAN CRC engine: mode encodings, CRC widths,
// polynomials, init values and FSM state encoding.
package can_crc_pkg;

  typedef enum logic [1:0] {
    MODE_15  = 2'b00,
    MODE_17  = 2'b01,
    MODE_21  = 2'b10,
    MODE_RSV = 2'b11
  } crc_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACCUM = 2'b01,
    ST_SEQ   = 2'b10,
    ST_DONE  = 2'b11
  } crc_state_e;

  localparam logic [4:0]  CRC_W_15 = 5'd15;
  localparam logic [4:0]  CRC_W_17 = 5'd17;
  localparam logic [4:0]  CRC_W_21 = 5'd21;

  localparam logic [20:0] POLY_15 = 21'h004599;
  localparam logic [20:0] POLY_17 = 21'h01685B;
  localparam logic [20:0] POLY_21 = 21'h102899;

  localparam logic [20:0] INIT_15 = 21'h000000;
  localparam logic [20:0] INIT_17 = 21'h010000;
  localparam logic [20:0] INIT_21 = 21'h100000;

  typedef struct packed {
    logic [4:0]  w;
    logic [20:0] poly;
    logic [20:0] init;
  } crc_cfg_t;

  // Ones in bits [w-1:0]; keeps the register clear above the active width.
  function automatic logic [20:0] width_mask(input logic [4:0] w);
    return (21'h1 << w) - 21'h1;
  endfunction

endpackage

// File: rtl/can_crc_gen_if.sv
// Handshake/bus bundle between the frame FSMs (master) and the CRC engine (slave).
interface can_crc_gen_if #(
  parameter int DATA_W = 8
);
  logic              start_i;
  logic [1:0]        mode_i;
  logic              valid_i;
  logic              ready_o;
  logic [DATA_W-1:0] data_i;
  logic [3:0]        nbits_i;
  logic              last_i;
  logic              bit_stb_i;
  logic              rx_bit_i;
  logic [20:0]       crc_o;
  logic              busy_o;
  logic              crc_bit_o;
  logic              crc_bit_vld_o;
  logic              done_o;
  logic              crc_ok_o;
  logic              crc_err_o;

  modport master (
    output start_i, mode_i, valid_i, data_i, nbits_i, last_i, bit_stb_i, rx_bit_i,
    input  ready_o, crc_o, busy_o, crc_bit_o, crc_bit_vld_o, done_o, crc_ok_o, crc_err_o
  );

  modport slave (
    input  start_i, mode_i, valid_i, data_i, nbits_i, last_i, bit_stb_i, rx_bit_i,
    output ready_o, crc_o, busy_o, crc_bit_o, crc_bit_vld_o, done_o, crc_ok_o, crc_err_o
  );
endinterface

// File: rtl/can_crc_step.sv
// Combinational CRC update: applies nbits MSB-first serial steps of data to crc_in
// in one pass. Out-of-range nbits (0 or > DATA_W) leaves the CRC unchanged.
module can_crc_step
  import can_crc_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [20:0]       crc_in,
  input  logic [DATA_W-1:0] data,
  input  logic [3:0]        nbits,
  input  logic [4:0]        w,
  input  logic [20:0]       poly,
  output logic [20:0]       crc_out
);

  logic [DATA_W-1:0] bit_seq;
  logic [DATA_W-1:0] bit_en;
  logic [20:0]       mask;
  logic [20:0]       top;
  logic              nbits_ok;

  // bit_seq[0] is the first bit on the wire.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_bit
      assign bit_seq[gi] = data[DATA_W-1-gi];
      assign bit_en[gi]  = (4'(gi) < nbits);
    end
  endgenerate

  assign mask     = width_mask(w);
  assign top      = 21'h1 << (w - 5'd1);
  assign nbits_ok = (nbits != 4'd0) && (nbits <= 4'(DATA_W));

  always_comb begin
    logic [20:0] c;
    c = crc_in;
    for (int i = 0; i < DATA_W; i++) begin
      if (bit_en[i]) begin
        if (bit_seq[i] ^ (|(c & top))) c = ((c << 1) & mask) ^ poly;
        else                           c = (c << 1) & mask;
      end
    end
    crc_out = nbits_ok ? c : crc_in;
  end

endmodule

// File: rtl/can_crc_gen.sv
// CAN CRC engine: accumulates data beats, then serialises/compares the CRC MSB-first.
// Define CAN_CRC_FD_EN to compile in the CRC-17/CRC-21 paths; otherwise CRC-15 only.
module can_crc_gen
  import can_crc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 5
) (
  input logic          clk_can_i,
  input logic          rst_i,
  can_crc_gen_if.slave bus
);

  crc_state_e       state_reg, state_next;
  logic [20:0]      crc_reg, crc_next;
  logic [20:0]      poly_reg, poly_next;
  logic [4:0]       w_reg, w_next;
  logic [CNT_W-1:0] idx_reg, idx_next;
  logic             err_reg, err_next;
  logic             ok_reg, ok_next;
  logic [20:0]      step_crc;
  crc_cfg_t         cfg;
  logic             beat_acc, strobe, cur_bit, mismatch;

`ifdef CAN_CRC_FD_EN
  always_comb begin
    case (crc_mode_e'(bus.mode_i))
      MODE_17: cfg = '{w: CRC_W_17, poly: POLY_17, init: INIT_17};
      MODE_21: cfg = '{w: CRC_W_21, poly: POLY_21, init: INIT_21};
      default: cfg = '{w: CRC_W_15, poly: POLY_15, init: INIT_15};
    endcase
  end
`else
  logic [1:0] unused_mode;
  assign unused_mode = bus.mode_i;
  assign cfg = '{w: CRC_W_15, poly: POLY_15, init: INIT_15};
`endif

  // start_i wins over a same-cycle beat or strobe.
  assign beat_acc = bus.valid_i && (state_reg == ST_ACCUM) && !bus.start_i;
  assign strobe   = bus.bit_stb_i && (state_reg == ST_SEQ) && !bus.start_i;
  assign cur_bit  = crc_reg[idx_reg];
  assign mismatch = bus.rx_bit_i ^ cur_bit;

  can_crc_step #(.DATA_W(DATA_W)) u_step (
    .crc_in  (crc_reg),
    .data    (bus.data_i),
    .nbits   (bus.nbits_i),
    .w       (w_reg),
    .poly    (poly_reg),
    .crc_out (step_crc)
  );

  always_ff @(posedge clk_can_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
      crc_reg   <= '0;
      poly_reg  <= POLY_15;
      w_reg     <= CRC_W_15;
      idx_reg   <= '0;
      err_reg   <= 1'b0;
      ok_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      crc_reg   <= crc_next;
      poly_reg  <= poly_next;
      w_reg     <= w_next;
      idx_reg   <= idx_next;
      err_reg   <= err_next;
      ok_reg    <= ok_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    crc_next   = crc_reg;
    poly_next  = poly_reg;
    w_next     = w_reg;
    idx_next   = idx_reg;
    err_next   = err_reg;
    ok_next    = ok_reg;
    if (bus.start_i) begin
      state_next = ST_ACCUM;
      crc_next   = cfg.init;
      poly_next  = cfg.poly;
      w_next     = cfg.w;
      err_next   = 1'b0;
      ok_next    = 1'b0;
    end else begin
      case (state_reg)
        ST_ACCUM: begin
          if (beat_acc) begin
            crc_next = step_crc;
            if (bus.last_i) begin
              state_next = ST_SEQ;
              idx_next   = CNT_W'(w_reg - 5'd1);
            end
          end
        end
        ST_SEQ: begin
          if (strobe) begin
            if (mismatch) err_next = 1'b1;
            if (idx_reg == '0) begin
              state_next = ST_DONE;
              ok_next    = !(err_reg || mismatch);
            end else begin
              idx_next = idx_reg - CNT_W'(1);
            end
          end
        end
        ST_DONE: state_next = ST_IDLE;
        default: state_next = state_reg;
      endcase
    end
  end

  always_comb begin
    bus.ready_o       = (state_reg == ST_ACCUM);
    bus.busy_o        = (state_reg != ST_IDLE);
    bus.crc_bit_vld_o = (state_reg == ST_SEQ);
    bus.crc_bit_o     = (state_reg == ST_SEQ) ? cur_bit : 1'b0;
    bus.done_o        = (state_reg == ST_DONE);
    bus.crc_ok_o      = ok_reg;
    bus.crc_err_o     = err_reg;
    bus.crc_o         = crc_reg;
  end

endmodule
